// File: rtl/bcd_operand_sequencer.sv
// rtl/bcd_operand_sequencer.sv - keypad BCD digit collector producing operand pairs A/B for the ALU
// Two digits per operand, converted as tens*10+units, handed off with op_valid/op_ready.
module bcd_operand_sequencer #(
  parameter logic [3:0] KEY_ENTER = 4'd10,
  parameter logic [3:0] KEY_CLEAR = 4'd11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [6:0] op_a,
  output logic [6:0] op_b,
  output logic       op_valid,
  input  logic       op_ready,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_units,
  output logic       entry_stage,
  output logic       key_err
);

  typedef enum logic [1:0] {S_A, S_B, S_HOLD} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic [6:0] op_a_q, op_a_d;
  logic [6:0] op_b_q, op_b_d;
  logic       op_valid_q, op_valid_d;
  logic       key_err_q, key_err_d;
  logic [6:0] value;
  logic       is_digit;

  // tens*10 as tens*8 + tens*2; at most 99, so 7 bits never overflow
  assign value    = {tens_q, 3'b000} + {2'b00, tens_q, 1'b0} + {3'b000, units_q};
  assign is_digit = (key_code <= 4'd9);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tens_d    = tens_q;
    units_d   = units_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    key_err_d = 1'b0;

    if (key_valid) begin
      if (key_code == KEY_CLEAR) begin
        tens_d  = 4'd0;
        units_d = 4'd0;
        cnt_d   = 2'd0;
        state_d = S_A;
      end else if (state_q == S_HOLD) begin
        key_err_d = 1'b1;
      end else if (is_digit) begin
        if (cnt_q == 2'd0) begin
          units_d = key_code;
          cnt_d   = 2'd1;
        end else if (cnt_q == 2'd1) begin
          tens_d  = units_q;
          units_d = key_code;
          cnt_d   = 2'd2;
        end else begin
          key_err_d = 1'b1;
        end
      end else if (key_code == KEY_ENTER) begin
        if (state_q == S_A) begin
          op_a_d  = value;
          state_d = S_B;
        end else begin
          op_b_d  = value;
          state_d = S_HOLD;
        end
        tens_d  = 4'd0;
        units_d = 4'd0;
        cnt_d   = 2'd0;
      end else begin
        key_err_d = 1'b1;
      end
    end

    // A completed handshake wins over anything keyed in the same cycle
    if (state_q == S_HOLD && op_valid_q && op_ready) begin
      state_d = S_A;
    end

    op_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_A;
      cnt_q      <= 2'd0;
      tens_q     <= 4'd0;
      units_q    <= 4'd0;
      op_a_q     <= 7'd0;
      op_b_q     <= 7'd0;
      op_valid_q <= 1'b0;
      key_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
      key_err_q  <= key_err_d;
    end
  end

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_valid    = op_valid_q;
  assign digit_tens  = tens_q;
  assign digit_units = units_q;
  assign entry_stage = (state_q == S_B);
  assign key_err     = key_err_q;

endmodule

// File: tb/tb_bcd_operand_sequencer.sv
// tb/tb_bcd_operand_sequencer.sv - scoreboard bench for bcd_operand_sequencer
module tb_bcd_operand_sequencer;

  localparam logic [3:0] ENT = 4'd10;
  localparam logic [3:0] CLR = 4'd11;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic [6:0] op_a;
  logic [6:0] op_b;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] digit_tens;
  logic [3:0] digit_units;
  logic       entry_stage;
  logic       key_err;

  int vectors = 0;
  int miscompares = 0;
  int err_cnt = 0;
  int xfer_cnt = 0;
  logic [13:0] sb_q[$];

  bcd_operand_sequencer dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .digit_tens(digit_tens), .digit_units(digit_units),
    .entry_stage(entry_stage), .key_err(key_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted pair is compared against the oldest expectation
  always @(negedge clk) begin
    if (!rst && key_err) err_cnt++;
    if (!rst && op_valid && op_ready) begin
      xfer_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_transfer", 1, 0);
      end else begin
        logic [13:0] e;
        e = sb_q.pop_front();
        chk("xfer_op_a", int'(op_a), int'(e[13:7]));
        chk("xfer_op_b", int'(op_b), int'(e[6:0]));
      end
    end
  end

  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic expect_pair(input int a, input int b);
    logic [6:0] a7, b7;
    a7 = 7'(a);
    b7 = 7'(b);
    sb_q.push_back({a7, b7});
  endtask

  task automatic accept();
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_op_a"}, int'(op_a), 0);
    chk({tag, "_op_b"}, int'(op_b), 0);
    chk({tag, "_op_valid"}, int'(op_valid), 0);
    chk({tag, "_tens"}, int'(digit_tens), 0);
    chk({tag, "_units"}, int'(digit_units), 0);
    chk({tag, "_stage"}, int'(entry_stage), 0);
    chk({tag, "_key_err"}, int'(key_err), 0);
  endtask

  initial begin
    int e0;
    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; op_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_zero("reset");

    // 42 then 7
    expect_pair(42, 7);
    press(4); press(2);
    chk("t1_tens", int'(digit_tens), 4);
    chk("t1_units", int'(digit_units), 2);
    press(ENT);
    chk("t1_stage_b", int'(entry_stage), 1);
    chk("t1_digits_cleared", int'({digit_tens, digit_units}), 0);
    press(7);
    chk("t1_valid_early", int'(op_valid), 0);
    press(ENT);
    chk("t1_valid", int'(op_valid), 1);
    chk("t1_op_a", int'(op_a), 42);
    chk("t1_op_b", int'(op_b), 7);
    accept();
    chk("t1_valid_drop", int'(op_valid), 0);
    chk("t1_stage_a", int'(entry_stage), 0);

    // third digit rejected, empty ENTER yields 0
    expect_pair(99, 0);
    e0 = err_cnt;
    press(9); press(9); press(5);
    chk("t2_err_pulse", int'(key_err), 1);
    chk("t2_tens", int'(digit_tens), 9);
    chk("t2_units", int'(digit_units), 9);
    press(ENT);
    chk("t2_err_count", err_cnt - e0, 1);
    press(ENT);
    chk("t2_valid", int'(op_valid), 1);
    accept();

    // CLEAR mid-entry of B
    press(3); press(ENT); press(6); press(CLR);
    chk("t3_stage", int'(entry_stage), 0);
    chk("t3_digits", int'({digit_tens, digit_units}), 0);
    chk("t3_valid", int'(op_valid), 0);
    chk("t3_op_a_kept", int'(op_a), 3);
    expect_pair(1, 2);
    press(1); press(ENT); press(2); press(ENT);
    accept();

    // keys rejected while holding
    expect_pair(64, 13);
    press(6); press(4); press(ENT); press(1); press(3); press(ENT);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_valid_held", int'(op_valid), 1);
    e0 = err_cnt;
    press(8); press(4'd13);
    @(posedge clk); #1;
    chk("t4_err_count", err_cnt - e0, 2);
    chk("t4_op_a", int'(op_a), 64);
    chk("t4_op_b", int'(op_b), 13);
    chk("t4_valid", int'(op_valid), 1);
    accept();

    // reset mid-entry
    press(5); press(ENT); press(6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero("t5_reset");
    expect_pair(10, 20);
    press(1); press(0); press(ENT); press(2); press(0); press(ENT);
    accept();

    // handshake coinciding with CLEAR
    expect_pair(8, 9);
    press(8); press(ENT); press(9); press(ENT);
    op_ready = 1'b1; key_valid = 1'b1; key_code = CLR;
    @(posedge clk); #1;
    op_ready = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    chk("t6_valid", int'(op_valid), 0);
    chk("t6_stage", int'(entry_stage), 0);
    op_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 op_ready = 1'b0;

    chk("sb_drained", sb_q.size(), 0);
    chk("xfer_total", xfer_cnt, 6);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
